timer_bank: RTL

TIMER_BANK -- requirements
Module: timer_bank

---
 rtl/timer_pkg.sv | 48 ++++
 rtl/timer_chan.sv | 120 ++++++++++++
 rtl/timer_bank.sv | 118 +++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared types and helpers for the countdown timer bank.
// State enum, BCD byte type, BCD constants, decrement and clamp helpers.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_RING  = 2'd3
  } chan_state_t;

  typedef logic [7:0] bcd8_t;

  localparam bcd8_t BCD_59   = 8'h59;
  localparam bcd8_t BCD_ZERO = 8'h00;

  // Decrement one two-digit BCD byte; the caller guarantees a nonzero input.
  function automatic bcd8_t bcd_dec(input bcd8_t v);
    if (v[3:0] == 4'h0) return {v[7:4] - 4'h1, 4'h9};
    else                return v - 8'h01;
  endfunction

  // Saturate a BCD byte at an upper limit.
  function automatic bcd8_t bcd_clamp(input bcd8_t v, input bcd8_t lim);
    return (v > lim) ? lim : v;
  endfunction

  // One-second decrement of H:M:S with borrow; seconds and minutes wrap 00 -> 59.
  function automatic logic [23:0] hms_dec(input bcd8_t h, input bcd8_t m, input bcd8_t s);
    bcd8_t nh, nm, ns;
    nh = h;
    nm = m;
    ns = s;
    if (s != BCD_ZERO) begin
      ns = bcd_dec(s);
    end else begin
      ns = BCD_59;
      if (m != BCD_ZERO) begin
        nm = bcd_dec(m);
      end else begin
        nm = BCD_59;
        nh = bcd_dec(h);
      end
    end
    return {nh, nm, ns};
  endfunction

endpackage

// File: rtl/timer_chan.sv
// One countdown channel: IDLE/RUN/PAUSE/RING FSM, BCD count, preset, mode
// and ring-duration counter. Commands arrive already decoded for this channel.
module timer_chan
  import timer_pkg::*;
#(
  parameter int          RING_SEC = 60,
  parameter logic [7:0]  HOUR_MAX = 8'h23
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        lead,
  input  logic        exp_pulse,
  input  logic        cs,
  input  logic        mode,
  input  bcd8_t       d_h,
  input  bcd8_t       d_m,
  input  bcd8_t       d_s,
  output bcd8_t       q_h,
  output bcd8_t       q_m,
  output bcd8_t       q_s,
  output logic        run,
  output logic        ring,
  output chan_state_t state_dbg
);

  localparam int RW = (RING_SEC > 1) ? $clog2(RING_SEC) : 1;
  localparam logic [RW-1:0] RING_LAST = RW'(RING_SEC - 1);

  chan_state_t   state, state_n;
  logic [23:0]   cnt, cnt_n;
  logic [23:0]   preset, preset_n;
  logic          mode_q, mode_n;
  logic [RW-1:0] ring_cnt, ring_n;

  logic [23:0]   load_val;
  logic [23:0]   dec_val;
  logic          cs_act;
  logic          exp_act;

  // Clamped preset, decremented count, and which commands actually apply in this state.
  always_comb begin
    load_val = {bcd_clamp(d_h, HOUR_MAX), bcd_clamp(d_m, BCD_59), bcd_clamp(d_s, BCD_59)};
    dec_val  = hms_dec(cnt[23:16], cnt[15:8], cnt[7:0]);
    cs_act   = cs && (state == ST_RING);
    exp_act  = exp_pulse && ((state == ST_RUN) || (state == ST_PAUSE));
  end

  // Next-state logic; priority LEAD > CS > EXPORT > TICK, ignored commands fall through.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    preset_n = preset;
    mode_n   = mode_q;
    ring_n   = ring_cnt;
    if (lead) begin
      preset_n = load_val;
      cnt_n    = load_val;
      mode_n   = mode;
      ring_n   = '0;
      state_n  = (load_val == 24'h0) ? ST_IDLE : ST_RUN;
    end else if (cs_act) begin
      state_n = ST_IDLE;
      cnt_n   = 24'h0;
      ring_n  = '0;
    end else if (exp_act) begin
      state_n = (state == ST_RUN) ? ST_PAUSE : ST_RUN;
    end else if (tick) begin
      case (state)
        ST_RUN: begin
          cnt_n = dec_val;
          if (dec_val == 24'h0) begin
            state_n = ST_RING;
            ring_n  = '0;
          end
        end
        ST_RING: begin
          if (ring_cnt == RING_LAST) begin
            ring_n = '0;
            if (mode_q) begin
              cnt_n   = preset;
              state_n = ST_RUN;
            end else begin
              cnt_n   = 24'h0;
              state_n = ST_IDLE;
            end
          end else begin
            ring_n = ring_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= 24'h0;
      preset   <= 24'h0;
      mode_q   <= 1'b0;
      ring_cnt <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      preset   <= preset_n;
      mode_q   <= mode_n;
      ring_cnt <= ring_n;
    end
  end

  assign q_h       = cnt[23:16];
  assign q_m       = cnt[15:8];
  assign q_s       = cnt[7:0];
  assign run       = (state == ST_RUN);
  assign ring      = (state == ST_RING);
  assign state_dbg = state;

endmodule

// File: rtl/timer_bank.sv
// Bank of N_CH independent BCD countdown timers sharing one 1 Hz TICK.
// SEL routes LEAD/EXPORT/CS to one channel and picks the channel shown on Q_*.
// Optional macro TIMER_BANK_COLON_EN adds the COLON blink output.
// dbg_state carries every channel's FSM state, 2 bits per channel.
module timer_bank
  import timer_pkg::*;
#(
  parameter int         N_CH     = 4,
  parameter int         RING_SEC = 60,
  parameter logic [7:0] HOUR_MAX = 8'h23
) (
  input  logic                                  CLK10K,
  input  logic                                  CR,
  input  logic                                  TICK,
  input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] SEL,
  input  logic [7:0]                            D_H,
  input  logic [7:0]                            D_M,
  input  logic [7:0]                            D_S,
  input  logic                                  MODE,
  input  logic                                  LEAD,
  input  logic                                  EXPORT,
  input  logic                                  CS,
  output logic [7:0]                            Q_H,
  output logic [7:0]                            Q_M,
  output logic [7:0]                            Q_S,
  output logic [N_CH-1:0]                       RUN,
  output logic [N_CH-1:0]                       RING,
  output logic                                  AUDIO,
`ifdef TIMER_BANK_COLON_EN
  output logic                                  COLON,
`endif
  output logic [2*N_CH-1:0]                     dbg_state
);

  localparam int SW = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH-1:0] lead_v, exp_v, cs_v;
  bcd8_t           qh [N_CH];
  bcd8_t           qm [N_CH];
  bcd8_t           qs [N_CH];
  chan_state_t     st [N_CH];

  // Command decode; a SEL past the last channel matches nothing.
  always_comb begin
    lead_v = '0;
    exp_v  = '0;
    cs_v   = '0;
    for (int i = 0; i < N_CH; i++) begin
      if ({1'b0, SEL} == (SW + 1)'(i)) begin
        lead_v[i] = LEAD;
        exp_v[i]  = EXPORT;
        cs_v[i]   = CS;
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    timer_chan #(
      .RING_SEC (RING_SEC),
      .HOUR_MAX (HOUR_MAX)
    ) u_chan (
      .clk       (CLK10K),
      .rst       (CR),
      .tick      (TICK),
      .lead      (lead_v[g]),
      .exp_pulse (exp_v[g]),
      .cs        (cs_v[g]),
      .mode      (MODE),
      .d_h       (D_H),
      .d_m       (D_M),
      .d_s       (D_S),
      .q_h       (qh[g]),
      .q_m       (qm[g]),
      .q_s       (qs[g]),
      .run       (RUN[g]),
      .ring      (RING[g]),
      .state_dbg (st[g])
    );
    assign dbg_state[2*g +: 2] = st[g];
  end

  // Display mux for the selected channel; invalid SEL reads zero.
  always_comb begin
    Q_H = BCD_ZERO;
    Q_M = BCD_ZERO;
    Q_S = BCD_ZERO;
    for (int i = 0; i < N_CH; i++) begin
      if ({1'b0, SEL} == (SW + 1)'(i)) begin
        Q_H = qh[i];
        Q_M = qm[i];
        Q_S = qs[i];
      end
    end
  end

  assign AUDIO = |RING;

`ifdef TIMER_BANK_COLON_EN
  logic sel_run;

  // RUN flag of the selected channel drives the colon blink.
  always_comb begin
    sel_run = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if ({1'b0, SEL} == (SW + 1)'(i)) sel_run = RUN[i];
    end
  end

  // Colon blinks once per TICK while the shown channel runs, steady on otherwise.
  always_ff @(posedge CLK10K or posedge CR) begin
    if (CR)           COLON <= 1'b1;
    else if (sel_run) begin
      if (TICK)       COLON <= ~COLON;
    end else          COLON <= 1'b1;
  end
`endif

endmodule
